// File: rtl/clk_speed_switch_ctrl.sv
// clk_speed_switch_ctrl
// Owns the gen_speed select of the clock divider and sequences glitch-safe
// speed changes: gate the derived clocks, hold the divider in reset while
// the select moves, let the new clocks settle, then ungate. Single clock
// domain (local_clk), asynchronous active-low reset.
module clk_speed_switch_ctrl #(
    parameter logic [1:0] RESET_SPEED   = 2'b00,
    parameter int         QUIET_CYCLES  = 4,
    parameter int         RST_CYCLES    = 2,
    parameter int         SETTLE_CYCLES = 66
) (
    input  logic       local_clk,
    input  logic       rst,
    input  logic       req_valid,
    input  logic [1:0] req_speed,
    output logic       req_ready,
    output logic [1:0] gen_speed,
    output logic       clk_gate_n,
    output logic       div_rst_n,
    output logic       busy,
    output logic       done,
    output logic       err
);

    // Elaboration-time guard on the counter load values (8-bit counter).
    if (QUIET_CYCLES < 1 || QUIET_CYCLES > 255) begin : g_bad_quiet
        $error("QUIET_CYCLES must be in 1..255");
    end
    if (RST_CYCLES < 1 || RST_CYCLES > 255) begin : g_bad_rst
        $error("RST_CYCLES must be in 1..255");
    end
    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 255) begin : g_bad_settle
        $error("SETTLE_CYCLES must be in 1..255");
    end

    // Counter reload values: a phase of N cycles counts N-1 down to 0.
    localparam logic [7:0] QUIET_LOAD  = 8'(QUIET_CYCLES - 1);
    localparam logic [7:0] RST_LOAD    = 8'(RST_CYCLES - 1);
    localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);

    localparam logic [1:0] SPEED_ILLEGAL = 2'b11;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        GATE   = 2'b01,
        DRST   = 2'b10,
        SETTLE = 2'b11
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [1:0] target_q, target_d;
    logic [1:0] gen_q, gen_d;
    logic       gate_n_q, gate_n_d;
    logic       drst_n_q, drst_n_d;
    logic       done_q, done_d;
    logic       err_q, err_d;

    // State register; reset drops any switch in progress back to IDLE.
    always_ff @(posedge local_clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and registered-output decode for the switch sequence.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        target_d = target_q;
        gen_d    = gen_q;
        gate_n_d = gate_n_q;
        drst_n_d = drst_n_q;
        done_d   = 1'b0;
        err_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                // req_ready is high throughout IDLE, so req_valid alone is the handshake.
                if (req_valid) begin
                    if (req_speed == SPEED_ILLEGAL) begin
                        err_d = 1'b1;
                    end else if (req_speed == gen_q) begin
                        // Already running at the requested speed: acknowledge without gating.
                        done_d = 1'b1;
                    end else begin
                        target_d = req_speed;
                        gate_n_d = 1'b0;
                        cnt_d    = QUIET_LOAD;
                        state_d  = GATE;
                    end
                end
            end
            GATE: begin
                if (cnt_q == 8'd0) begin
                    // The select moves only together with the divider reset, under the gate.
                    gen_d    = target_q;
                    drst_n_d = 1'b0;
                    cnt_d    = RST_LOAD;
                    state_d  = DRST;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            DRST: begin
                if (cnt_q == 8'd0) begin
                    drst_n_d = 1'b1;
                    cnt_d    = SETTLE_LOAD;
                    state_d  = SETTLE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            SETTLE: begin
                if (cnt_q == 8'd0) begin
                    gate_n_d = 1'b1;
                    done_d   = 1'b1;
                    state_d  = IDLE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Registered control outputs and phase counter.
    always_ff @(posedge local_clk or negedge rst) begin
        if (!rst) begin
            cnt_q    <= 8'd0;
            gen_q    <= RESET_SPEED;
            gate_n_q <= 1'b1;
            drst_n_q <= 1'b1;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            gen_q    <= gen_d;
            gate_n_q <= gate_n_d;
            drst_n_q <= drst_n_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    // Latched request target; only meaningful while a switch is in flight.
    always_ff @(posedge local_clk) begin
        target_q <= target_d;
    end

    assign req_ready  = (state_q == IDLE);
    assign busy       = (state_q != IDLE);
    assign gen_speed  = gen_q;
    assign clk_gate_n = gate_n_q;
    assign div_rst_n  = drst_n_q;
    assign done       = done_q;
    assign err        = err_q;

    // done and err come from mutually exclusive branches of the IDLE decode.
    a_done_err_excl : assert property (@(posedge local_clk) !(done && err));

endmodule

// File: doc/clk_speed_switch_ctrl.md
# clk_speed_switch_ctrl

Sequencer that owns the `gen_speed` select of the clock divider and performs glitch-safe speed changes on request. It sits between link training (requester) and the clock divider. The switch has four steps: gate the downstream derived clocks, hold the divider counters in reset while the select changes, let the new divided clocks settle, then ungate. Runs entirely on the local clock.

## Interface
Parameters:
- `RESET_SPEED`, default 2'b00: `gen_speed` value after reset (00 gen4, 01 gen3, 10 gen2).
- `QUIET_CYCLES`, default 4: cycles with the gate closed before the divider is reset. Legal range 1..255.
- `RST_CYCLES`, default 2: cycles `div_rst_n` is held low. Legal range 1..255.
- `SETTLE_CYCLES`, default 66: cycles after the divider reset is released before ungating. 66 covers the longest `enc_clk` period. Legal range 1..255.

Ports:
- `local_clk` in 1: fast local clock. All logic is posedge.
- `rst` in 1: reset, asynchronous, active-low.
- `req_valid` in 1: speed-change request.
- `req_speed` in 2: requested generation code. 11 is illegal.
- `req_ready` out 1: high only in IDLE.
- `gen_speed` out 2: registered select to the clock divider.
- `clk_gate_n` out 1: active-low gate enable for downstream derived clocks. 0 means gated.
- `div_rst_n` out 1: active-low reset to the divider counters. ANDed with `rst` at the divider.
- `busy` out 1: high in any state other than IDLE.
- `done` out 1: one-cycle pulse when the requested speed is active.
- `err` out 1: one-cycle pulse when a request is rejected.

## Operation
- States: IDLE, GATE, DRST, SETTLE. There is an 8-bit down-counter `cnt`.
- IDLE: `req_ready` = 1. When the handshake `req_valid & req_ready` is sampled:
  - `req_speed` == 11: `err` <= 1, stay in IDLE, `gen_speed` unchanged.
  - `req_speed` == `gen_speed`: `done` <= 1, stay in IDLE, no gating (null switch).
  - Otherwise: latch `target` <= `req_speed`, `clk_gate_n` <= 0, `cnt` <= QUIET_CYCLES-1, go to GATE.
- GATE: when `cnt` == 0, `gen_speed` <= `target`, `div_rst_n` <= 0, `cnt` <= RST_CYCLES-1, go to DRST. Otherwise decrement `cnt`.
- DRST: when `cnt` == 0, `div_rst_n` <= 1, `cnt` <= SETTLE_CYCLES-1, go to SETTLE. Otherwise decrement `cnt`.
- SETTLE: when `cnt` == 0, `clk_gate_n` <= 1, `done` <= 1, go to IDLE. Otherwise decrement `cnt`.
- Invariant: `gen_speed` changes only on the cycle `div_rst_n` falls, and only while `clk_gate_n` = 0.
- `req_valid` while `busy` is ignored and not queued. The requester holds `req_valid` until `req_ready` is high.
- `req_speed` is sampled only at the handshake. Changes to it afterwards have no effect on the switch in progress.
- `done` and `err` are never both high in the same cycle. Each is high for exactly one cycle per event.
- Back-to-back requests: a new handshake is possible on the first IDLE cycle after `done`.
- Reset asserted mid-operation: all outputs return to their reset values immediately. `gen_speed` = RESET_SPEED, `target` is discarded, no `done` is issued.

## Timing
- Reset values:
  - `gen_speed` = RESET_SPEED
  - `clk_gate_n` = 1
  - `div_rst_n` = 1
  - `done` = 0
  - `err` = 0
  - `busy` = 0
  - `req_ready` = 1
  - state = IDLE
- All outputs are registered except `req_ready` and `busy`, which decode the state directly.
- Let the handshake be sampled at edge T. Then:
  - Edge T: `clk_gate_n` falls, `busy` rises.
  - Edge T+QUIET_CYCLES: `gen_speed` updates and `div_rst_n` falls.
  - Edge T+QUIET_CYCLES+RST_CYCLES: `div_rst_n` rises.
  - Edge T+QUIET_CYCLES+RST_CYCLES+SETTLE_CYCLES: `clk_gate_n` rises, `done` pulses, `busy` falls.
- With default parameters, the total switch latency is 72 cycles.
- Null switch and illegal request: `done` / `err` is high in cycle T+1 only, and `busy` stays 0.
- Minimum parameter values (all 1) give a 3-cycle switch. No state may be skipped.

## Test plan
- Reset check: release reset → `gen_speed` = 00, `clk_gate_n` = 1, `div_rst_n` = 1, `req_ready` = 1, `done` = `err` = 0.
- Normal switch: from 00, request 10 with default parameters → `clk_gate_n` low for edges T..T+71, `gen_speed` = 10 from edge T+4, `div_rst_n` low for exactly 2 cycles, `done` pulse at T+72.
- Null and illegal requests: request equal to the current `gen_speed` → `done` pulse at T+1, `clk_gate_n` never falls. Request 11 → `err` pulse at T+1, `gen_speed` unchanged.
- Busy request and back-to-back: request 01, then toggle `req_valid`/`req_speed` = 10 during the switch → ignored, `gen_speed` = 01 at `done`. A new 10 request on the first IDLE cycle completes normally.
- Reset mid-switch: assert `rst` during DRST → `gen_speed` = RESET_SPEED, `div_rst_n` = 1, `clk_gate_n` = 1 immediately, no `done` after release.
- Minimum parameters (1, 1, 1): request 01 → `gen_speed` updates at T+1, `div_rst_n` low for 1 cycle, `done` at T+3.
